ram_stream_reader: RTL and testbench



---
 rtl/ram_stream_reader_pkg.sv | 28 ++
 rtl/ram_stream_skid_fifo.sv | 55 +++++
 rtl/ram_stream_reader.sv | 130 +++++++++++++
 tb/tb_ram_stream_reader.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_stream_reader_pkg.sv
// Shared types and constants for the RAM stream reader.
// Used by ram_stream_reader and ram_stream_skid_fifo.
package ram_stream_reader_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 6;
    localparam int FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // A slot is free when words already buffered, plus the read whose
    // data is on the RAM bus now, minus the word leaving this cycle,
    // still leaves room in the FIFO.
    function automatic logic has_credit(
        input logic [1:0] lvl,
        input logic       inflight,
        input logic       pop
    );
        logic [2:0] occ;
        occ = {1'b0, lvl} + {2'b00, inflight} - {2'b00, pop};
        return occ < 3'(FIFO_DEPTH);
    endfunction

endpackage

// File: rtl/ram_stream_skid_fifo.sv
// Two-entry synchronous FIFO buffering RAM read data.
// Head entry drives the stream output directly.
module ram_stream_skid_fifo
    import ram_stream_reader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic              pop_ok;
    logic              push_ok;

    assign full    = (cnt == CNT_W'(FIFO_DEPTH));
    assign empty   = (cnt == '0);
    assign head    = mem[rd_ptr];
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Storage, pointers and occupancy; push and pop may coincide.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            cnt <= cnt + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

endmodule

// File: rtl/ram_stream_reader.sv
// Read sequencer: RAM read port to valid/ready byte stream.
// Optional out_last port enabled by RAM_STREAM_READER_LAST_EN.
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   length,
    output logic [ADDR_W-1:0] read_addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
`ifdef RAM_STREAM_READER_LAST_EN
    ,
    output logic              out_last
`endif
);

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   issue_left;
    logic              pend_q;

    logic              fifo_full;
    logic              fifo_empty;
    logic [1:0]        level;
    logic [1:0]        level_after;
    logic              pop;
    logic              issue;
    logic              last_issue;
    logic              drain_done;

    assign read_addr = addr_q;
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;

    assign level       = {fifo_full, !fifo_full && !fifo_empty};
    assign level_after = level - {1'b0, pop};

    assign issue      = (state == ISSUE) && has_credit(level, pend_q, pop);
    assign last_issue = issue && (issue_left == (ADDR_W + 1)'(1));
    assign drain_done = (state == DRAIN) && !pend_q && (level_after == '0);

    ram_stream_skid_fifo #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (pend_q),
        .wdata (data_in),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (out_data)
    );

    // Control FSM with address counter, read tracking and status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_q     <= '0;
            issue_left <= '0;
            pend_q     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done   <= 1'b0;
            pend_q <= issue;
            if (issue) begin
                addr_q     <= addr_q + ADDR_W'(1);
                issue_left <= issue_left - (ADDR_W + 1)'(1);
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (length == '0) begin
                            done <= 1'b1;
                        end else begin
                            addr_q     <= start_addr;
                            issue_left <= length;
                            busy       <= 1'b1;
                            state      <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (last_issue) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef RAM_STREAM_READER_LAST_EN
    logic [ADDR_W:0] beats_left;

    assign out_last = out_valid && (beats_left == (ADDR_W + 1)'(1));

    // Beats still to be delivered; the final one carries out_last.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beats_left <= '0;
        end else if (state == IDLE && start && length != '0) begin
            beats_left <= length;
        end else if (pop) begin
            beats_left <= beats_left - (ADDR_W + 1)'(1);
        end
    end
`endif

endmodule

// File: tb/tb_ram_stream_reader.sv
// Scoreboard bench for ram_stream_reader.
// Builds with or without RAM_STREAM_READER_LAST_EN.
module tb_ram_stream_reader;

    localparam int DW = 8;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW:0]   length;
    logic [AW-1:0] read_addr;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;
`ifdef RAM_STREAM_READER_LAST_EN
    logic          out_last;
`endif

    logic [DW-1:0] ram [64];
    int            cyc = 0;
    int            n_chk = 0;
    int            n_fail = 0;

    typedef struct {
        int data;
        int cyc;
        int last;
    } exp_t;

    exp_t bq[$];
    int   dq[$];
    exp_t mon_e;
    int   mon_d;
    logic prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always #5 clk = ~clk;

    // Registered RAM read port model.
    always @(posedge clk) data_in <= ram[read_addr];

    // Cycle counter for latency checks.
    always @(posedge clk) cyc <= cyc + 1;

    ram_stream_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .read_addr  (read_addr),
        .data_in    (data_in),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
`ifdef RAM_STREAM_READER_LAST_EN
        ,
        .out_last   (out_last)
`endif
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic start_xfer(input int sa, input int n,
                              input bit timed, output int t0);
        exp_t e;
        @(posedge clk);
        #1;
        start_addr = AW'(sa);
        length     = (AW + 1)'(n);
        start      = 1'b1;
        t0         = cyc;
        for (int i = 0; i < n; i++) begin
            e.data = (((sa + i) % 64) + 16) & 255;
            e.cyc  = timed ? t0 + 3 + i : -1;
            e.last = (i == n - 1) ? 1 : 0;
            bq.push_back(e);
        end
        if (n == 0) dq.push_back(t0 + 1);
        else        dq.push_back(timed ? t0 + n + 3 : -1);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        for (int i = 0; i < 400; i++) begin
            if (bq.size() == 0 && dq.size() == 0) break;
            @(posedge clk);
        end
        chk(nm, bq.size() + dq.size(), 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Monitor: pops expectations on handshakes and done pulses.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", int'(out_valid), 1);
                chk("stall_data", int'(out_data), int'(prev_data));
            end
            if (out_valid && out_ready) begin
                chk("beat_pending", int'(bq.size() != 0), 1);
                if (bq.size() != 0) begin
                    mon_e = bq.pop_front();
                    chk("beat_data", int'(out_data), mon_e.data);
                    if (mon_e.cyc >= 0) chk("beat_cycle", cyc, mon_e.cyc);
`ifdef RAM_STREAM_READER_LAST_EN
                    chk("out_last", int'(out_last), mon_e.last);
`endif
                end
            end
`ifdef RAM_STREAM_READER_LAST_EN
            if (out_last) chk("last_needs_valid", int'(out_valid), 1);
`endif
            if (done) begin
                chk("done_pending", int'(dq.size() != 0), 1);
                if (dq.size() != 0) begin
                    mon_d = dq.pop_front();
                    if (mon_d >= 0) chk("done_cycle", cyc, mon_d);
                end
                chk("busy_at_done", int'(busy), 0);
            end
            if (busy) begin
                chk("fifo_no_overflow",
                    int'(dut.u_fifo.push && dut.u_fifo.full), 0);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    // Directed stimulus sequence.
    initial begin
        int t0;
        for (int i = 0; i < 64; i++) ram[i] = DW'(i + 16);
        rst_n      = 1'b0;
        start      = 1'b0;
        start_addr = '0;
        length     = '0;
        out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_read_addr", int'(read_addr), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
`ifdef RAM_STREAM_READER_LAST_EN
        chk("rst_out_last", int'(out_last), 0);
`endif
        rst_n = 1'b1;

        // basic read: 0x14,0x15,0x16 in cycles 3..5, done in 6
        start_xfer(4, 3, 1'b1, t0);
        chk("basic_busy_c1", int'(busy), 1);
        chk("basic_addr_c1", int'(read_addr), 4);
        wait_drain("basic_drain");

        // wrap-around: addresses 62,63,0,1 in cycles 1..4
        start_xfer(62, 4, 1'b1, t0);
        chk("wrap_addr_c1", int'(read_addr), 62);
        for (int i = 1; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("wrap_addr", int'(read_addr), (62 + i) % 64);
        end
        wait_drain("wrap_drain");

        // backpressure: ready pattern 1,0,0 repeating
        start_xfer(20, 8, 1'b0, t0);
        for (int i = 0; i < 40; i++) begin
            out_ready = (i % 3 == 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        wait_drain("bp_drain");

        // zero length: done one cycle after start, no beats
        start_xfer(10, 0, 1'b1, t0);
        chk("zero_busy_c1", int'(busy), 0);
        chk("zero_valid_c1", int'(out_valid), 0);
        wait_drain("zero_drain");

        // reset at cycle 4 of a 16-beat read
        start_xfer(0, 16, 1'b1, t0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_addr", int'(read_addr), 0);
        chk("mid_rst_data", int'(out_data), 0);
        chk("mid_rst_beats_left", bq.size(), 15);
        bq.delete();
        dq.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        chk("mid_rst_idle", int'(busy), 0);

        // second start while busy is ignored
        start_xfer(30, 16, 1'b1, t0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        start_addr = '0;
        length     = 7'd2;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_drain("ign_drain");
        chk("ign_idle_valid", int'(out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    // Global time bound.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
